// File: rtl/mmio_io_bank.sv
// Memory-mapped I/O bank: synchronised, debounced input channels, RW output registers,
// sticky change flags with write-1-to-clear, an interrupt mask and a registered level irq.
module mmio_io_bank #(
    parameter logic [31:0] BASE_ADDR       = 32'd4096,
    parameter int unsigned N_IN            = 2,
    parameter int unsigned N_OUT           = 2,
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    input  logic                   wren,
    output logic [31:0]            rdata,
    output logic                   hit,
    input  logic [N_IN*WIDTH-1:0]  in_pins,
    output logic [N_OUT*WIDTH-1:0] out_pins,
    output logic                   irq
);

    localparam int unsigned S_OFF    = N_IN + N_OUT;
    localparam int unsigned MASK_OFF = S_OFF + 1;
    localparam int unsigned MAP_SIZE = S_OFF + 2;
    localparam int unsigned CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [31:0]                      off;
    logic [SYNC_STAGES-1:0][N_IN*WIDTH-1:0] sync_q;
    logic [N_IN-1:0][WIDTH-1:0]       sync_w;
    logic [N_IN-1:0][WIDTH-1:0]       prev_q;
    logic [N_IN-1:0][WIDTH-1:0]       stable_q;
    logic [N_IN-1:0][WIDTH-1:0]       stable_d;
    logic [N_IN-1:0][CW-1:0]          cnt_q;
    logic [N_IN-1:0][CW-1:0]          cnt_n;
    logic [N_IN-1:0][CW-1:0]          cnt_d;
    logic [N_IN-1:0]                  accept;
    logic [N_OUT-1:0][WIDTH-1:0]      out_q;
    logic [N_OUT-1:0]                 wr_out;
    logic [N_IN-1:0]                  chg_q;
    logic [N_IN-1:0]                  chg_d;
    logic [N_IN-1:0]                  mask_q;
    logic                             wr_chg;
    logic                             wr_mask;
    logic                             irq_q;
    logic                             unused_wdata;

    // Unsigned wrap makes addresses below BASE_ADDR fall outside the map too.
    assign off     = addr - BASE_ADDR;
    assign hit     = off < 32'(MAP_SIZE);
    assign sync_w  = sync_q[SYNC_STAGES-1];
    assign wr_chg  = wren && (off == 32'(S_OFF));
    assign wr_mask = wren && (off == 32'(MASK_OFF));
    assign out_pins     = out_q;
    assign irq          = irq_q;
    assign unused_wdata = ^wdata;

    // Input synchroniser chains.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= in_pins;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Debounce: a value is accepted on the edge its run length reaches DEBOUNCE_CYCLES.
    always_comb begin
        cnt_n    = '0;
        cnt_d    = '0;
        accept   = '0;
        stable_d = stable_q;
        for (int i = 0; i < int'(N_IN); i++) begin
            if ((sync_w[i] == stable_q[i]) || (sync_w[i] != prev_q[i])) begin
                cnt_n[i] = '0;
            end else begin
                cnt_n[i] = cnt_q[i] + CW'(1);
            end
            accept[i] = (sync_w[i] != stable_q[i]) && (cnt_n[i] == CNT_MAX);
            cnt_d[i]  = accept[i] ? '0 : cnt_n[i];
            if (accept[i]) begin
                stable_d[i] = sync_w[i];
            end
        end
    end

    // Write decode for the output registers.
    always_comb begin
        wr_out = '0;
        for (int j = 0; j < int'(N_OUT); j++) begin
            wr_out[j] = wren && (off == 32'(N_IN + j));
        end
    end

    // A new change on the same edge as a clear wins.
    assign chg_d = (chg_q & ~(wr_chg ? wdata[N_IN-1:0] : '0)) | accept;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            chg_q    <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            prev_q   <= sync_w;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            chg_q    <= chg_d;
            irq_q    <= |(chg_q & mask_q);
            if (wr_mask) begin
                mask_q <= wdata[N_IN-1:0];
            end
            for (int j = 0; j < int'(N_OUT); j++) begin
                if (wr_out[j]) begin
                    out_q[j] <= wdata[WIDTH-1:0];
                end
            end
        end
    end

    // Read mux; nothing matches when addr is outside the map.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (off == 32'(i)) begin
                rdata = 32'(stable_q[i]);
            end
        end
        for (int j = 0; j < int'(N_OUT); j++) begin
            if (off == 32'(N_IN + j)) begin
                rdata = 32'(out_q[j]);
            end
        end
        if (off == 32'(S_OFF)) begin
            rdata = 32'(chg_q);
        end
        if (off == 32'(MASK_OFF)) begin
            rdata = 32'(mask_q);
        end
    end

endmodule

// File: tb/tb_mmio_io_bank.sv
// Directed bench for mmio_io_bank with a queue scoreboard of expected read-back values.
module tb_mmio_io_bank;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wren;
    logic [31:0] rdata;
    logic        hit;
    logic [31:0] in_pins;
    logic [31:0] out_pins;
    logic        irq;

    string       tag_q[$];
    logic [31:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    mmio_io_bank dut (
        .clock    (clock),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .wren     (wren),
        .rdata    (rdata),
        .hit      (hit),
        .in_pins  (in_pins),
        .out_pins (out_pins),
        .irq      (irq)
    );

    always #10 clock = ~clock;

    task automatic push_exp(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_v(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h, no expected entry", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic rd_chk(input logic [31:0] a);
        addr = a;
        wren = 1'b0;
        #1;
        check_v(rdata);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wren  = 1'b1;
        @(posedge clock);
        #1;
        wren  = 1'b0;
        addr  = 32'd0;
    endtask

    initial begin
        reset   = 1'b0;
        addr    = 32'd0;
        wdata   = 32'd0;
        wren    = 1'b0;
        in_pins = 32'd0;

        // Reset held while pins and bus are exercised.
        for (int k = 0; k < 6; k++) begin
            in_pins = $urandom;
            addr    = 32'd4098;
            wdata   = $urandom;
            wren    = 1'b1;
            step(1);
        end
        wren = 1'b0;
        push_exp("rst_out_pins", 32'd0);  check_v(out_pins);
        push_exp("rst_irq", 32'd0);       check_v({31'b0, irq});
        push_exp("rst_in0", 32'd0);       rd_chk(32'd4096);
        in_pins = 32'd0;
        step(1);
        reset = 1'b1;
        step(8);
        push_exp("post_rst_in0", 32'd0);  rd_chk(32'd4096);
        push_exp("post_rst_out0", 32'd0); rd_chk(32'd4098);
        push_exp("post_rst_chg", 32'd0);  rd_chk(32'd4100);
        push_exp("post_rst_mask", 32'd0); rd_chk(32'd4101);
        push_exp("post_rst_irq", 32'd0);  check_v({31'b0, irq});

        // Input latency: visible 6 cycles after the pin change, not 5.
        in_pins[15:0] = 16'hA5A5;
        push_exp("in0_at_5", 32'd0);
        push_exp("in0_at_6", 32'h0000_A5A5);
        push_exp("chg_after_in0", 32'h1);
        step(5);
        rd_chk(32'd4096);
        step(1);
        rd_chk(32'd4096);
        rd_chk(32'd4100);

        // Bouncing channel 1 is never accepted.
        for (int k = 0; k < 10; k++) begin
            in_pins[16] = ~in_pins[16];
            step(2);
        end
        step(8);
        push_exp("bounce_in1", 32'd0);    rd_chk(32'd4097);
        push_exp("bounce_chg", 32'h1);    rd_chk(32'd4100);

        // Output register write; read shows the pre-write value in the write cycle.
        addr  = 32'd4098;
        wdata = 32'hFFFF_1234;
        wren  = 1'b1;
        push_exp("out0_prewrite", 32'd0);
        #1;
        check_v(rdata);
        @(posedge clock);
        #1;
        wren = 1'b0;
        push_exp("out_pins_lo", 32'h0000_1234); check_v({16'b0, out_pins[15:0]});
        push_exp("out0_read", 32'h0000_1234);   rd_chk(32'd4098);
        wr(32'd4096, 32'h0000_0000);
        push_exp("in0_ro", 32'h0000_A5A5);      rd_chk(32'd4096);

        addr  = 32'd4104;
        wdata = 32'hFFFF_FFFF;
        wren  = 1'b1;
        push_exp("hit_4104", 32'd0);
        push_exp("rdata_4104", 32'd0);
        #1;
        check_v({31'b0, hit});
        check_v(rdata);
        @(posedge clock);
        #1;
        wr(32'd4095, 32'hFFFF_FFFF);
        push_exp("oob_out0", 32'h0000_1234);    rd_chk(32'd4098);
        push_exp("oob_out1", 32'd0);            rd_chk(32'd4099);
        push_exp("oob_chg", 32'h1);             rd_chk(32'd4100);
        push_exp("oob_mask", 32'd0);            rd_chk(32'd4101);

        // Interrupt path.
        wr(32'd4100, 32'h1);
        wr(32'd4101, 32'h1);
        push_exp("irq_idle", 32'd0);            check_v({31'b0, irq});
        push_exp("mask_read", 32'h1);           rd_chk(32'd4101);
        in_pins[15:0] = 16'h5A5A;
        push_exp("chg_set", 32'h1);
        push_exp("irq_lag", 32'd0);
        push_exp("irq_set", 32'd1);
        step(6);
        rd_chk(32'd4100);
        check_v({31'b0, irq});
        step(1);
        check_v({31'b0, irq});
        wr(32'd4100, 32'h1);
        push_exp("chg_cleared", 32'd0);         rd_chk(32'd4100);
        push_exp("irq_hold", 32'd1);            check_v({31'b0, irq});
        step(1);
        push_exp("irq_clear", 32'd0);           check_v({31'b0, irq});

        // Clear on the same edge as a new change: set wins.
        in_pins[15:0] = 16'h0F0F;
        step(5);
        wr(32'd4100, 32'h1);
        push_exp("set_wins_chg", 32'h1);        rd_chk(32'd4100);
        push_exp("set_wins_in0", 32'h0000_0F0F); rd_chk(32'd4096);

        // Reset in the middle of a debounce window.
        wr(32'd4100, 32'h1);
        in_pins[15:0] = 16'h1111;
        step(4);
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
        push_exp("midrst_in0", 32'd0);          rd_chk(32'd4096);
        push_exp("midrst_chg", 32'd0);          rd_chk(32'd4100);
        push_exp("midrst_mask", 32'd0);         rd_chk(32'd4101);
        push_exp("midrst_out0", 32'd0);         rd_chk(32'd4098);
        push_exp("midrst_irq", 32'd0);          check_v({31'b0, irq});
        step(5);
        push_exp("reaccept_in0", 32'h0000_1111); rd_chk(32'd4096);
        push_exp("reaccept_chg", 32'h1);        rd_chk(32'd4100);

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
